// File: rtl/pmem_fetch_ctrl_pkg.sv
// Shared constants for the program-memory fetch controller.
// State codes are plain constants so older tools can read them too.
package pmem_fetch_ctrl_pkg;

  localparam int AW_DEF       = 8;
  localparam int IW_DEF       = 12;
  localparam int RESET_PC_DEF = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/pmem_fetch_ctrl_pc_next_sel.sv
// Next-PC select: sequential increment or taken-branch target.
// Increment wraps modulo 2^AW.
module pmem_fetch_ctrl_pc_next_sel #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] pc,
  input  logic          br_take,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc_nxt
);

  assign pc_nxt = br_take ? br_target : pc + 1'b1;

endmodule

// File: rtl/pmem_fetch_ctrl.sv
// Program-memory sequencer: loads the 256x12 store, then
// fetches and issues instructions with branch/halt control.
module pmem_fetch_ctrl
  import pmem_fetch_ctrl_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int IW       = IW_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run,
  output logic          pm_e,
  output logic [AW-1:0] pm_addr,
  input  logic [IW-1:0] pm_i,
  output logic          pm_le,
  output logic [AW-1:0] pm_la,
  output logic [IW-1:0] pm_li,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          br_take,
  input  logic [AW-1:0] br_target,
  input  logic          halt,
  output logic [AW-1:0] pc,
  output logic [AW:0]   load_count,
  output logic          busy
);

  localparam logic [AW-1:0] PC0     = AW'(RESET_PC);
  localparam logic [AW-1:0] PTR_MAX = '1;

  logic [2:0]    state;
  logic [AW-1:0] ld_ptr;
  logic [AW-1:0] pc_nxt;
  logic          in_load;
  logic          in_fetch;
  logic          in_issue;

  assign in_load  = state == ST_LOAD;
  assign in_fetch = state == ST_FETCH;
  assign in_issue = state == ST_ISSUE;

  pmem_fetch_ctrl_pc_next_sel #(
    .AW(AW)
  ) u_pc_next_sel (
    .pc       (pc),
    .br_take  (br_take),
    .br_target(br_target),
    .pc_nxt   (pc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= PC0;
      ir         <= '0;
      load_count <= '0;
      ld_ptr     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (load_start) begin
            state      <= ST_LOAD;
            ld_ptr     <= '0;
            load_count <= '0;
          end else if (run) begin
            state <= ST_FETCH;
            pc    <= PC0;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            load_count <= load_count + 1'b1;
            // Pointer saturates; the top address ends the load.
            if (ld_ptr != PTR_MAX)
              ld_ptr <= ld_ptr + 1'b1;
            if (ld_last || ld_ptr == PTR_MAX)
              state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          ir    <= pm_i;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (ir_ready) begin
            pc    <= pc_nxt;
            state <= halt ? ST_HALTED : ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Load port is a pass-through so the memory writes on this edge.
  assign ld_ready = in_load;
  assign pm_le    = in_load && ld_valid;
  assign pm_la    = in_load ? ld_ptr : '0;
  assign pm_li    = in_load ? ld_data : '0;

  assign pm_e     = in_fetch;
  assign pm_addr  = pc;
  assign ir_valid = in_issue;
  assign busy     = in_load || in_fetch || in_issue;

endmodule

// File: tb/tb_pmem_fetch_ctrl.sv
// Scoreboard bench for pmem_fetch_ctrl with a behavioural
// memory image and PC model.
module tb_pmem_fetch_ctrl;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        load_start = 0;
  logic        ld_valid = 0;
  logic [11:0] ld_data = '0;
  logic        ld_last = 0;
  logic        ld_ready;
  logic        run = 0;
  logic        pm_e;
  logic [7:0]  pm_addr;
  logic [11:0] pm_i;
  logic        pm_le;
  logic [7:0]  pm_la;
  logic [11:0] pm_li;
  logic [11:0] ir;
  logic        ir_valid;
  logic        ir_ready = 0;
  logic        br_take = 0;
  logic [7:0]  br_target = '0;
  logic        halt = 0;
  logic [7:0]  pc;
  logic [8:0]  load_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] a; logic [11:0] d; } wr_t;
  typedef struct { logic [11:0] d; logic [7:0] a; } is_t;
  wr_t wr_q[$];
  is_t ir_q[$];

  logic [11:0] mem [256];
  logic [11:0] ref_mem [256];
  logic [7:0]  mpc;
  logic [7:0]  lptr;

  pmem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .run(run), .pm_e(pm_e),
    .pm_addr(pm_addr), .pm_i(pm_i), .pm_le(pm_le),
    .pm_la(pm_la), .pm_li(pm_li), .ir(ir),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_take(br_take), .br_target(br_target), .halt(halt),
    .pc(pc), .load_count(load_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pm_le) mem[pm_la] <= pm_li;
  assign pm_i = mem[pm_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pm_le) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", int'(pm_la), -1);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", int'(pm_la), int'(w.a));
        chk("wr_data", int'(pm_li), int'(w.d));
      end
    end
    if (rst_n && ir_valid && ir_ready) begin
      if (ir_q.size() == 0) begin
        chk("unexpected_issue", int'(ir), -1);
      end else begin
        is_t e;
        e = ir_q.pop_front();
        chk("ir", int'(ir), int'(e.d));
        chk("ir_pc", int'(pc), int'(e.a));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    load_start = 1; tick(); load_start = 0;
    lptr = 8'd0;
  endtask

  task automatic load_word(input logic [11:0] d, input bit last,
                           input int gap);
    repeat (gap) tick();
    ld_valid = 1; ld_data = d; ld_last = last;
    wr_q.push_back('{lptr, d});
    ref_mem[lptr] = d;
    lptr = lptr + 8'd1;
    tick();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic start_run();
    run = 1; tick(); run = 0;
    mpc = 8'd0;
    ir_q.push_back('{ref_mem[mpc], mpc});
  endtask

  task automatic step(input int stall, input bit bt,
                      input logic [7:0] tg, input bit h);
    int n = 0;
    if (!ir_valid) begin
      chk("fetch_e", int'(pm_e), 1);
      chk("fetch_addr", int'(pm_addr), int'(mpc));
    end
    while (!ir_valid && n < 8) begin tick(); n++; end
    chk("issue_latency", n, 1);
    repeat (stall) tick();
    if (stall > 0) begin
      chk("stall_ir", int'(ir), int'(ref_mem[mpc]));
      chk("stall_pc", int'(pc), int'(mpc));
      chk("stall_pm_e", int'(pm_e), 0);
    end
    ir_ready = 1; br_take = bt; br_target = tg; halt = h;
    tick();
    ir_ready = 0; br_take = 0; br_target = '0; halt = 0;
    mpc = bt ? tg : mpc + 8'd1;
    if (h) begin
      chk("halt_valid", int'(ir_valid), 0);
      chk("halt_busy", int'(busy), 0);
    end else begin
      ir_q.push_back('{ref_mem[mpc], mpc});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mpc = '0;
    lptr = '0;
    #12;
    chk("rst_pc", int'(pc), 0);
    chk("rst_ir", int'(ir), 0);
    chk("rst_ir_valid", int'(ir_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ld_ready", int'(ld_ready), 0);
    chk("rst_pm_e", int'(pm_e), 0);
    chk("rst_pm_le", int'(pm_le), 0);
    chk("rst_load_count", int'(load_count), 0);
    chk("rst_pm_la", int'(pm_la), 0);
    @(posedge clk); #1; rst_n = 1;
    tick();

    start_load();
    load_word(12'h101, 0, 0);
    load_word(12'h202, 0, 2);
    load_word(12'h303, 1, 1);
    chk("load3_count", int'(load_count), 3);
    chk("load3_busy", int'(busy), 0);
    chk("load3_ready", int'(ld_ready), 0);

    start_run();
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("pc_after3", int'(pc), 3);
    step(5, 1, 8'h80, 0);
    step(0, 1, 8'hFF, 0);
    step(0, 0, 8'h00, 0);
    chk("pc_wrap", int'(pc), 0);
    step(0, 0, 8'h00, 1);

    load_start = 1; run = 1; tick();
    load_start = 0; run = 0;
    lptr = 8'd0;
    chk("both_ld_ready", int'(ld_ready), 1);
    chk("both_pm_e", int'(pm_e), 0);
    chk("both_busy", int'(busy), 1);
    chk("both_count", int'(load_count), 0);
    for (int i = 0; i < 256; i++)
      load_word(12'($urandom), 0, int'($urandom_range(0, 1)));
    chk("full_count", int'(load_count), 256);
    chk("full_busy", int'(busy), 0);
    ld_valid = 1; ld_data = 12'hABC;
    #1;
    chk("over_ready", int'(ld_ready), 0);
    chk("over_le", int'(pm_le), 0);
    tick();
    ld_valid = 0;

    start_run();
    for (int i = 0; i < 30; i++)
      step(int'($urandom_range(0, 3)), ($urandom % 4) == 0,
           8'($urandom), i == 29);

    start_run();
    step(0, 0, 8'h00, 0);
    tick();
    chk("pre_rst_valid", int'(ir_valid), 1);
    #3 rst_n = 0;
    #1;
    chk("async_valid", int'(ir_valid), 0);
    chk("async_pc", int'(pc), 0);
    chk("async_busy", int'(busy), 0);
    ir_q.delete();
    tick();
    rst_n = 1;
    tick();
    start_run();
    step(0, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);

    repeat (2) tick();
    chk("ir_q_empty", ir_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_fetch_ctrl.md
Name: pmem_fetch_ctrl

Overview:
- Sequencer that owns the 256x12 program memory ports, the PC increment and the branch-select path.
- Phase 1, program load: accepts a stream of 12-bit words over a valid/ready handshake and drives the memory load port (LE/LA/LI) at consecutive addresses.
- Phase 2, run: walks the PC, reads instructions through the memory read port (E/Addr/I), and presents each one to the execute unit over a valid/ready handshake.
- The next PC is PC+1 or a branch target supplied at handshake time.

Parameters:
- AW, 8, program address width (memory depth 2^AW).
- IW, 12, instruction width.
- RESET_PC, 0, PC value loaded on reset and on every run start.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse; enter LOAD (honoured only in IDLE/HALTED)
- ld_valid  in  1  load word valid
- ld_data  in  IW  load word
- ld_last  in  1  marks final load word (qualified by ld_valid)
- ld_ready  out  1  controller accepts load word
- run  in  1  pulse; start execution from RESET_PC (honoured only in IDLE/HALTED)
- pm_e  out  1  memory read enable
- pm_addr  out  AW  memory read address
- pm_i  in  IW  memory read data (combinational from pm_addr)
- pm_le  out  1  memory load enable
- pm_la  out  AW  memory load address
- pm_li  out  IW  memory load data
- ir  out  IW  registered current instruction
- ir_valid  out  1  ir holds an instruction for the execute unit
- ir_ready  in  1  execute unit consumes ir
- br_take  in  1  branch taken, sampled on the ir handshake
- br_target  in  AW  branch destination, sampled with br_take
- halt  in  1  stop after current instruction, sampled on the ir handshake
- pc  out  AW  current program counter
- load_count  out  AW+1  words written in the last load (0..256)
- busy  out  1  state is LOAD, FETCH or ISSUE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=RESET_PC; ir=0; load_count=0.
  - All outputs 0 except pc.
  - Internal load pointer=0.
- States: IDLE, LOAD, FETCH, ISSUE, HALTED.
- IDLE/HALTED:
  - load_start -> LOAD, load pointer=0, load_count=0.
  - run -> FETCH, pc=RESET_PC.
  - If both in the same cycle, load_start wins.
  - Both inputs ignored in all other states.
- LOAD:
  - ld_ready=1.
  - pm_le=ld_valid; pm_la=load pointer; pm_li=ld_data (combinational pass-through, so the memory writes on the same edge).
  - On each accepted word: pointer+1, load_count+1.
  - Exit to IDLE after accepting a word with ld_last=1, or after accepting the word at address 2^AW-1 (overflow guard; pointer does not wrap, load_count=256).
  - pm_e=0 throughout LOAD.
- FETCH (1 cycle):
  - pm_e=1, pm_addr=pc; ir<=pm_i at the clock edge.
  - -> ISSUE.
- ISSUE:
  - pm_e=0; ir_valid=1; ir stable until the handshake.
  - On ir_valid&&ir_ready:
    - pc <= br_take ? br_target : pc+1 (mod 2^AW; 255 -> 0 wraps silently).
    - If halt -> HALTED with ir_valid=0, else -> FETCH.
- Throughput and latency:
  - Throughput is one instruction per 2 cycles when ir_ready is held high.
  - Latency from run to first ir_valid is 2 cycles.
- pm_addr=pc whenever pm_e=0 (don't-care for the memory, fixed for lint/debug); pm_la/pm_li=0 outside LOAD.
- Reset asserted mid-LOAD or mid-ISSUE aborts immediately; memory contents are not cleared; ir_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, FETCH, ISSUE, HALTED);
  - AW/IW defaults;
  - RESET_PC constant.
- One natural sub-module, pc_next_sel: combinational pc+1 vs br_target selection.
- FSM and registers stay in the top.

Test Plan:
- Load 3 words 0x101,0x202,0x303 (last on 3rd) with ld_valid gaps -> pm_le pulses at pm_la=0,1,2 with matching pm_li; load_count=3; state returns to IDLE.
- Load 256 words with ld_last never asserted -> exit after addr 255; load_count=256; 257th ld_valid sees ld_ready=0.
- run with ir_ready=1, no branches -> ir sequence 0x101,0x202,0x303 with ir_valid every 2nd cycle; pc=3 after 3 handshakes.
- Hold ir_ready=0 for 5 cycles in ISSUE -> ir and pc stable, pm_e=0; handshake with br_take=1, br_target=0x80 -> next FETCH drives pm_addr=0x80.
- pc=0xFF handshake with no branch -> pc=0x00; handshake with halt=1 -> HALTED; then load_start and run together -> LOAD.
- rst_n low in mid-ISSUE -> ir_valid=0, pc=RESET_PC asynchronously; after release, run restarts fetch at addr 0 with memory intact.
